// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format codes, which match the
// control block's ImmSel encoding, base opcodes and the loader FSM state type.
package instr_enc_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  // Codes above FMT_R (110, 111) have no encoding.
  function automatic logic fmt_is_legal(input logic [2:0] fmt);
    return fmt <= FMT_R;
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Purely combinational RV32I field packer; doubles as a golden encoder in benches.
// Immediate bits outside the chosen format are dropped without any range check.
module instr_pack
  import instr_enc_pkg::*;
#(
  parameter int n = 32
) (
  input  logic [2:0]   fmt_i,
  input  logic [6:0]   opcode_i,
  input  logic [2:0]   funct3_i,
  input  logic [6:0]   funct7_i,
  input  logic [4:0]   rd_i,
  input  logic [4:0]   rs1_i,
  input  logic [4:0]   rs2_i,
  input  logic [n-1:0] imm_i,
  output logic [n-1:0] word_o,
  output logic         illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = !fmt_is_legal(fmt_i);
    case (fmt_i)
      FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
      FMT_U: word_o = {imm_i[31:12], rd_i, opcode_i};
      FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// IMEM loader: accepts field-level instruction requests, packs them into RV32I
// words and writes them one per cycle to consecutive IMEM addresses.
//
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high. req_ready depends only on registered state, the requester must
// hold fields stable while req_valid is high, and the write appears on the IMEM
// port for exactly the cycle following the transfer edge.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          finish,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_fmt,
  input  logic [6:0]    req_opcode,
  input  logic [2:0]    req_funct3,
  input  logic [6:0]    req_funct7,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [n-1:0]  req_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [n-1:0]  imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          err
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_A  = AW'(DEPTH - 1);

  enc_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   acc_q, acc_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [n-1:0]  wdata_q, wdata_d;

  logic [n-1:0]  packed_word;
  logic          packed_illegal;
  logic          hs;

  instr_pack #(.n(n)) u_pack (
    .fmt_i     (req_fmt),
    .opcode_i  (req_opcode),
    .funct3_i  (req_funct3),
    .funct7_i  (req_funct7),
    .rd_i      (req_rd),
    .rs1_i     (req_rs1),
    .rs2_i     (req_rs2),
    .imm_i     (req_imm),
    .word_o    (packed_word),
    .illegal_o (packed_illegal)
  );

  // State register; reset also drops any write still pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic; illegal requests still count toward the accepted total.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        if (finish)                          state_d = ST_IDLE;
        else if (hs && acc_q == DEPTH_W - 1) state_d = ST_FULL;
      end
      ST_FULL: if (finish) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic of the FSM.
  always_comb begin
    req_ready = (state_q == ST_LOAD) && (acc_q < DEPTH_W);
  end

  assign hs = req_valid && req_ready;

  always_comb begin
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    count_d = count_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (we_q) count_d = count_q + 1'b1;

    if (state_q == ST_IDLE && start) begin
      ptr_d   = base_addr;
      acc_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end

    if (hs) begin
      acc_d = acc_q + 1'b1;
      if (packed_illegal) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        addr_d  = ptr_q;
        wdata_d = packed_word;
        ptr_d   = (ptr_q == LAST_A) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (count_q == DEPTH_W);
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word IMEM so wrap and full are reachable.
module tb_instr_encoder;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst, start, finish, req_valid;
  logic [AW-1:0] base_addr;
  logic          req_ready;
  logic [2:0]    req_fmt, req_funct3;
  logic [6:0]    req_opcode, req_funct7;
  logic [4:0]    req_rd, req_rs1, req_rs2;
  logic [N-1:0]  req_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [N-1:0]  imem_wdata;
  logic [AW:0]   count;
  logic          full, err;

  int n_cmp = 0;
  int n_mis = 0;

  instr_encoder #(.n(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm);
    req_valid  = 1'b1;
    req_fmt    = fmt;
    req_opcode = op;
    req_funct3 = f3;
    req_funct7 = f7;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
  endtask

  task automatic begin_session(input logic [AW-1:0] base);
    start = 1'b1;
    base_addr = base;
    tick();
    start = 1'b0;
  endtask

  task automatic end_session();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d);
    check({tag, "_we"}, 32'(imem_we), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(a));
    check({tag, "_data"}, imem_wdata, d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; base_addr = '0;
    set_req(3'b000, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_valid = 1'b0;
    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_data", imem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Request offered while IDLE is ignored.
    set_req(3'b101, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req_valid = 1'b0;
    check("idle_ignored_we", 32'(imem_we), 32'd0);

    // add x3,x1,x2
    begin_session(2'd0);
    check("load_ready", 32'(req_ready), 32'd1);
    set_req(3'b101, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req_valid = 1'b0;
    check_write("add", 2'd0, 32'h002081B3);
    check("add_count_before", 32'(count), 32'd0);
    tick();
    check("add_we_low", 32'(imem_we), 32'd0);
    check("add_count", 32'(count), 32'd1);
    end_session();
    check("idle_ready", 32'(req_ready), 32'd0);

    // addi, sw, beq back-to-back
    begin_session(2'd0);
    set_req(3'b000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    check_write("addi", 2'd0, 32'h00500093);
    set_req(3'b001, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    check_write("sw", 2'd1, 32'h0020A423);
    set_req(3'b010, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    tick();
    req_valid = 1'b0;
    check_write("beq", 2'd2, 32'hFE208EE3);
    tick();
    check("b2b_count", 32'(count), 32'd3);
    end_session();

    // lui, then jal together with finish: still accepted and written
    begin_session(2'd0);
    set_req(3'b011, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
    tick();
    check_write("lui", 2'd0, 32'h123452B7);
    set_req(3'b100, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    req_valid = 1'b0;
    check_write("jal", 2'd1, 32'h001000EF);
    check("finish_ready", 32'(req_ready), 32'd0);
    tick();
    check("uj_count", 32'(count), 32'd2);

    // Wrap from base 2 and fill: five requests offered, four accepted
    begin_session(2'd2);
    for (int i = 0; i < 4; i++) begin
      set_req(3'b000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'(i));
      check($sformatf("wrap%0d_ready", i), 32'(req_ready), 32'd1);
      tick();
      check_write($sformatf("wrap%0d", i), 2'((i + 2) % 4), 32'h00000093 | (32'(i) << 20));
    end
    check("wrap_count3", 32'(count), 32'd3);
    check("wrap_full_early", 32'(full), 32'd0);
    set_req(3'b000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    tick();
    check("fifth_we", 32'(imem_we), 32'd0);
    check("full_count", 32'(count), 32'd4);
    check("full_flag", 32'(full), 32'd1);
    tick();
    check("fifth_still_we", 32'(imem_we), 32'd0);
    req_valid = 1'b0;
    end_session();

    // Illegal format: consumed, no write, sticky err
    begin_session(2'd1);
    set_req(3'b111, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req_valid = 1'b0;
    check("ill_we", 32'(imem_we), 32'd0);
    check("ill_err", 32'(err), 32'd1);
    tick();
    check("ill_count", 32'(count), 32'd0);
    set_req(3'b101, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    check_write("post_ill", 2'd1, 32'h002081B3);
    set_req(3'b110, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    check("ill110_we", 32'(imem_we), 32'd0);
    set_req(3'b000, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    tick();
    req_valid = 1'b0;
    check_write("ill_last", 2'd2, 32'h00500093);
    check("ill_total_ready", 32'(req_ready), 32'd0);
    tick();
    check("ill_count2", 32'(count), 32'd2);
    check("ill_full", 32'(full), 32'd0);
    check("ill_err_sticky", 32'(err), 32'd1);
    begin_session(2'd0);
    check("start_in_full_err", 32'(err), 32'd1);
    end_session();
    begin_session(2'd0);
    check("start_clears_err", 32'(err), 32'd0);

    // Reset in the cycle after a handshake
    set_req(3'b101, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_we", 32'(imem_we), 32'd0);
    check("rstmid_addr", 32'(imem_addr), 32'd0);
    check("rstmid_data", imem_wdata, 32'd0);
    check("rstmid_count", 32'(count), 32'd0);
    check("rstmid_ready", 32'(req_ready), 32'd0);
    set_req(3'b101, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    tick();
    req_valid = 1'b0;
    check("rstmid_needs_start", 32'(imem_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and IMEM loader: the inverse of `control`'s decode path. It accepts field-level instruction requests (format, opcode, funct3/funct7, register indices, immediate) over a valid/ready handshake. Each request is packed into a 32-bit RV32I word in a registered stage and written sequentially into the instruction-memory write port. The block sits beside IMEM and is used by the bring-up loader and by benches to build programs without a hex file.

## Interface
Parameters:
- `n`, 32, instruction/data width
- `DEPTH`, 256, IMEM words; `AW = $clog2(DEPTH)`

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a load session at `base_addr`.
- `base_addr` in AW: first IMEM word address, sampled on `start`.
- `finish` in 1: end the session.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_fmt` in 3: instruction format, `instr_enc_pkg` encoding.
- `req_opcode` in 7, `req_funct3` in 3, `req_funct7` in 7: opcode and function fields.
- `req_rd` in 5, `req_rs1` in 5, `req_rs2` in 5: register indices.
- `req_imm` in n: immediate as a byte offset or value.
- `imem_we` out 1, `imem_addr` out AW, `imem_wdata` out n: IMEM write port.
- `count` out AW+1: words written this session.
- `full` out 1: `count == DEPTH`.
- `err` out 1: sticky illegal-format flag.

## Operation
- FSM states: IDLE, LOAD, FULL.
- IDLE → LOAD on `start`. In the same edge: write pointer ← `base_addr`, `count` ← 0, `err` ← 0.
- LOAD:
  - `req_ready` = 1 while accepted-request total < DEPTH.
  - A handshake registers the encoded word plus a write-pending bit.
  - Each write increments `count` and advances the pointer modulo DEPTH (wraps to 0 after DEPTH-1 for any base).
- LOAD → FULL when the accepted-request total reaches DEPTH; `req_ready` = 0 in FULL.
- LOAD or FULL → IDLE on `finish`. A handshake in the same cycle as `finish` is still accepted and written.
- `start` outside IDLE is ignored. `req_valid` outside LOAD is ignored.
- Format codes, aligned to `ImmSel`: I=000, S=001, B=010, U=011, J=100, R=101.
- Encodings:
  - R: f7|rs2|rs1|f3|rd|op
  - I: imm[11:0]|rs1|f3|rd|op
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U: imm[31:12]|rd|op
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Immediate bits not in the format are discarded; there is no range check. B/J imm[0] is ignored.
- Formats 110 and 111 are illegal:
  - The request is still consumed (ready unaffected) and counts toward the accepted total.
  - No write occurs and `count` does not increment.
  - `err` sets and holds until `start` or `rst`.

## Timing
- Reset values: state IDLE, `req_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `count` 0, `full` 0, `err` 0.
- Latency: handshake at edge k gives `imem_we` = 1 with valid addr/data for exactly the cycle after edge k.
- Throughput is one word per cycle.
- `count` updates on the edge ending the write cycle.
- `req_ready` is a function of registered state only; it has no combinational path from `req_valid`.
- `rst` mid-session aborts immediately. A pending write is dropped, so `imem_we` = 0 in the cycle after reset.

## Structure
- `instr_enc_pkg` holds:
  - format localparams (shared with `control`'s `ImmSel`);
  - opcode constants: OP 0110011, OP_IMM 0010011, STORE 0100011, BRANCH 1100011, JAL 1101111, LUI 0110111;
  - the FSM state enum.
- Sub-module `instr_pack`: purely combinational field packer (fmt, fields → word, illegal flag). It is reusable by benches as a golden encoder.
- Top level holds the FSM, pointer, counters and output register.

## Test plan
- start base=0, R add x3,x1,x2 (op 0110011) → next cycle `imem_we` = 1, addr 0, data 0x002081B3; `count` = 1.
- Back-to-back I addi x1,x0,5, then S sw x2,8(x1) (f3 010), then B beq x1,x2,imm=-4 → data 0x00500093, 0x0020A423, 0xFE208EE3 on consecutive cycles at addr 0,1,2.
- U lui x5,0x12345000, then J jal x1,2048 → data 0x123452B7, 0x001000EF.
- DEPTH=4, base=2, 5 requests offered:
  - writes go to 2, 3, 0, 1;
  - `full` = 1 and `req_ready` = 0 after the 4th acceptance;
  - the 5th request is not accepted.
- fmt=111 request → no `imem_we`, `count` unchanged, `err` = 1 sticky. A following legal request writes to the next address.
- `rst` asserted in the cycle after a handshake → no write; all outputs return to reset values; `start` is required again.
